// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: a valid/ready boot loader fills the core from address 0,
// fetch is combinational by default or registered when INSTR_MEM_REG_OUT_EN is defined.
module instr_mem_loadable #(
    parameter int              IW        = 9,
    parameter int              DEPTH     = 1024,
    parameter int              PC_W      = 10,
    parameter int              AW        = $clog2(DEPTH),
    parameter logic [IW-1:0]   NOOP_WORD = '0,
    parameter                  INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc,
    output logic [IW-1:0]   instr,
    output logic            instr_valid,
    input  logic            ld_start,
    input  logic            ld_valid,
    input  logic [IW-1:0]   ld_data,
    input  logic            ld_last,
    output logic            ld_ready,
    output logic            ld_busy,
    output logic            ld_done,
    output logic            ld_err,
    output logic [AW:0]     ld_count
);

    // state | meaning
    // IDLE  | fetch enabled, loader blocked
    // LOAD  | loader accepts words, fetch returns NOOP_WORD
    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [PC_W:0] DEPTH_PC  = (PC_W + 1)'(DEPTH);

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   wptr_next;
    logic [AW:0]     count;
    logic [AW:0]     count_next;
    logic            err;
    logic            err_next;
    logic            done;
    logic            done_next;
    logic            accept;
    logic            mem_we;

    logic [IW-1:0]   core [DEPTH];

    assign ld_ready = (state == LOAD);
    assign ld_busy  = (state == LOAD);
    assign accept   = ld_valid & ld_ready;

    always_comb begin
        state_next = state;
        wptr_next  = wptr;
        count_next = count;
        err_next   = err;
        done_next  = 1'b0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (ld_start) begin
                    state_next = LOAD;
                    wptr_next  = '0;
                    count_next = '0;
                    err_next   = 1'b0;
                end
            end
            LOAD: begin
                // A restart wins over a same-cycle accept; that word is dropped.
                if (ld_start) begin
                    wptr_next  = '0;
                    count_next = '0;
                    err_next   = 1'b0;
                end else if (accept) begin
                    mem_we     = 1'b1;
                    wptr_next  = wptr + 1'b1;
                    count_next = count + 1'b1;
                    if (ld_last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if (wptr == LAST_ADDR) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        err_next   = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wptr  <= '0;
            count <= '0;
            err   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            wptr  <= wptr_next;
            count <= count_next;
            err   <= err_next;
            done  <= done_next;
        end
    end

    // Memory contents survive reset; only the write is gated.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            core[wptr] <= ld_data;
        end
    end

    assign ld_done  = done;
    assign ld_err   = err;
    assign ld_count = count;

    logic            fetch_valid;
    logic [IW-1:0]   fetch_word;

    assign fetch_valid = (state == IDLE) && ({1'b0, pc} < DEPTH_PC);
    assign fetch_word  = fetch_valid ? core[pc[AW-1:0]] : NOOP_WORD;

`ifdef INSTR_MEM_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instr       <= NOOP_WORD;
            instr_valid <= 1'b0;
        end else begin
            instr       <= fetch_word;
            instr_valid <= fetch_valid;
        end
    end
`else
    assign instr       = fetch_word;
    assign instr_valid = fetch_valid;
`endif

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable (DEPTH=8): directed loader scenarios plus random traffic,
// all outputs compared every cycle against a word-level model of the memory and loader.
module tb_instr_mem_loadable;

    localparam int IW = 9;
    localparam int DEPTH = 8;
    localparam int PC_W = 4;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [PC_W-1:0] pc = '0;
    logic [IW-1:0]   instr;
    logic            instr_valid;
    logic            ld_start = 1'b0;
    logic            ld_valid = 1'b0;
    logic [IW-1:0]   ld_data = '0;
    logic            ld_last = 1'b0;
    logic            ld_ready;
    logic            ld_busy;
    logic            ld_done;
    logic            ld_err;
    logic [AW:0]     ld_count;

    instr_mem_loadable #(.IW(IW), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .pc(pc), .instr(instr), .instr_valid(instr_valid),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err),
        .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Model: the memory as an array of words, the loader as "loading / next address / count".
    int  m_mem [DEPTH];
    bit  m_known [DEPTH];
    bit  m_loading = 0;
    int  m_ptr = 0;
    int  m_count = 0;
    bit  m_err = 0;
    bit  m_done = 0;
    bit  armed = 0;
    bit  r_valid = 0;
    bit  r_known = 1;
    int  r_instr = 0;

    always @(posedge clk) begin
        int p;
        p = int'(pc);
        if (reset) begin
            r_valid = 0; r_known = 1; r_instr = 0;
        end else begin
            r_valid = !m_loading && p < DEPTH;
            r_known = r_valid ? m_known[p % DEPTH] : 1'b1;
            r_instr = r_valid ? m_mem[p % DEPTH] : 0;
        end
        if (reset) begin
            armed = 1;
            m_loading = 0; m_ptr = 0; m_count = 0; m_err = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (ld_start) begin
                m_loading = 1; m_ptr = 0; m_count = 0; m_err = 0;
            end else if (m_loading && ld_valid) begin
                m_mem[m_ptr] = int'(ld_data);
                m_known[m_ptr] = 1;
                m_ptr++;
                m_count++;
                if (ld_last) begin
                    m_loading = 0; m_done = 1;
                end else if (m_ptr == DEPTH) begin
                    m_loading = 0; m_done = 1; m_err = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit e_valid;
        bit e_known;
        int e_instr;
        int p;
        #2;
        if (armed) begin
            p = int'(pc);
`ifdef INSTR_MEM_REG_OUT_EN
            e_valid = r_valid; e_known = r_known; e_instr = r_instr;
`else
            e_valid = !m_loading && p < DEPTH;
            e_known = e_valid ? m_known[p % DEPTH] : 1'b1;
            e_instr = e_valid ? m_mem[p % DEPTH] : 0;
`endif
            check("instr_valid", int'(instr_valid), int'(e_valid));
            if (e_known) check("instr", int'(instr), e_instr);
            check("ld_ready", int'(ld_ready), int'(m_loading));
            check("ld_busy", int'(ld_busy), int'(m_loading));
            check("ld_done", int'(ld_done), int'(m_done));
            check("ld_err", int'(ld_err), int'(m_err));
            check("ld_count", int'(ld_count), m_count);
        end
    end

    task automatic cyc(input logic s, input logic v, input logic [IW-1:0] d,
                       input logic l, input logic [PC_W-1:0] p, input logic r);
        @(negedge clk);
        reset = r; ld_start = s; ld_valid = v; ld_data = d; ld_last = l; pc = p;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 0; m_known[i] = 0;
        end
        repeat (3) cyc(0, 0, 0, 0, 0, 1);
        #3;
        check("rst_count", int'(ld_count), 0);
        check("rst_busy", int'(ld_busy), 0);
        check("rst_err", int'(ld_err), 0);
        check("rst_done", int'(ld_done), 0);

        // Four-word load with ld_last, with a gap in ld_valid.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 9'h101, 0, 0, 0);
        cyc(0, 1, 9'h102, 0, 0, 0);
        cyc(0, 0, 9'h1FF, 0, 0, 0);
        #3 check("gap_count", int'(ld_count), 2);
        cyc(0, 1, 9'h103, 0, 0, 0);
        cyc(0, 1, 9'h104, 1, 0, 0);
        cyc(0, 0, 0, 0, 3, 0);
        #3;
        check("load4_done", int'(ld_done), 1);
        check("load4_count", int'(ld_count), 4);
        check("load4_err", int'(ld_err), 0);
        cyc(0, 0, 0, 0, 3, 0);
        #3;
        check("load4_pc3", int'(instr), 9'h104);
        check("load4_done_clr", int'(ld_done), 0);

        // Overflow: DEPTH words without ld_last.
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, IW'(9'h010 + i), 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #3;
        check("ovf_done", int'(ld_done), 1);
        check("ovf_err", int'(ld_err), 1);
        check("ovf_count", int'(ld_count), 8);
        check("ovf_busy", int'(ld_busy), 0);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #3;
        check("restart_err", int'(ld_err), 0);
        check("load_pc0_valid", int'(instr_valid), 0);
        check("load_pc0_instr", int'(instr), 0);

        // Reset after 2 of 5 words.
        cyc(0, 1, 9'h1A0, 0, 0, 0);
        cyc(0, 1, 9'h1A1, 0, 0, 0);
        cyc(0, 1, 9'h1A2, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        #3 check("rst_mid_count", int'(ld_count), 0);
        cyc(0, 0, 0, 0, 2, 0);
        cyc(0, 0, 0, 0, 2, 0);
        #3 check("rst_mid_old", int'(instr), 9'h012);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #3 check("rst_mid_new", int'(instr), 9'h1A0);

        // ld_start during an accept drops that word.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 9'h055, 0, 0, 0);
        cyc(0, 1, 9'h066, 1, 0, 0);
        cyc(0, 0, 0, 0, 8, 0);
        #3 check("drop_count", int'(ld_count), 1);
        cyc(0, 0, 0, 0, 8, 0);
        #3;
        check("pc_oor_valid", int'(instr_valid), 0);
        check("pc_oor_instr", int'(instr), 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #3 check("drop_word", int'(instr), 9'h066);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(99, 0) < 3),
                logic'($urandom_range(99, 0) < 60),
                IW'($urandom),
                logic'($urandom_range(99, 0) < 15),
                PC_W'($urandom),
                logic'($urandom_range(199, 0) < 2));
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
